uart_cmd_decoder: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_byte_event.sv | 22 ++
 rtl/uart_cmd_decoder.sv | 146 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM encoding for the UART command decoder.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CHK_SEED  = 8'h5A;
    localparam logic [3:0] OP_WRITE  = 4'h1;

    typedef enum logic [1:0] {
        StHunt,
        StCmd,
        StData,
        StChk
    } state_e;

    function automatic logic [7:0] pkt_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data ^ CHK_SEED;
    endfunction

endpackage

// File: rtl/uart_byte_event.sv
// Turns the receiver's frame_valid level into a single-cycle byte event on its rising edge.
module uart_byte_event (
    input  logic clk_16bd,
    input  logic rst,
    input  logic frame_valid,
    output logic byte_evt
);

    logic fv_q;

    // Reset high so a level already present at reset release is not seen as a new byte.
    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            fv_q <= 1'b1;
        end else begin
            fv_q <= frame_valid;
        end
    end

    assign byte_evt = frame_valid & ~fv_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames 4-byte packets (sync, cmd, data, chk) from the UART byte stream into register writes.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_16bd,
    input  logic       rst,
    input  logic [8:0] frame,
    input  logic       frame_valid,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cmd_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic            byte_evt;
    logic [7:0]      rx_byte;
    logic            unused_frame_msb;
    logic            timeout;

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [3:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            cmd_err_q, cmd_err_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            busy_q, busy_d;

    uart_byte_event u_byte_event (
        .clk_16bd    (clk_16bd),
        .rst         (rst),
        .frame_valid (frame_valid),
        .byte_evt    (byte_evt)
    );

    assign rx_byte          = frame[7:0];
    assign unused_frame_msb = frame[8];
    assign timeout          = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cmd_err_d = 1'b0;

        if (state_q == StHunt || byte_evt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        // A byte on the timeout cycle takes priority over the timeout.
        unique case (state_q)
            StHunt: begin
                if (byte_evt && rx_byte == SYNC_BYTE) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (byte_evt) begin
                    cmd_d   = rx_byte;
                    state_d = StData;
                end else if (timeout) begin
                    cmd_err_d = 1'b1;
                    state_d   = StHunt;
                end
            end
            StData: begin
                if (byte_evt) begin
                    data_d  = rx_byte;
                    state_d = StChk;
                end else if (timeout) begin
                    cmd_err_d = 1'b1;
                    state_d   = StHunt;
                end
            end
            StChk: begin
                if (byte_evt) begin
                    state_d = StHunt;
                    if (rx_byte == pkt_chk(cmd_q, data_q) && cmd_q[7:4] == OP_WRITE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cmd_q[3:0];
                        wr_data_d = data_q;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    cmd_err_d = 1'b1;
                    state_d   = StHunt;
                end
            end
        endcase

        err_count_d = err_count_q;
        if (cmd_err_d && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end

        busy_d = (state_d != StHunt);
    end

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_q     <= StHunt;
            cmd_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cmd_err_q   <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cmd_err_q   <= cmd_err_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cmd_err   = cmd_err_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed, table-driven bench for uart_cmd_decoder.
module tb_uart_cmd_decoder;

    localparam int TO = 1024;

    logic       clk_16bd;
    logic       rst;
    logic [8:0] frame;
    logic       frame_valid;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cmd_err;
    logic [7:0] err_count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int err_pulses = 0;

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        logic       exp_wr;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_16bd    (clk_16bd),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cmd_err     (cmd_err),
        .err_count   (err_count),
        .busy        (busy)
    );

    initial clk_16bd = 1'b0;
    always #5 clk_16bd = ~clk_16bd;

    always @(negedge clk_16bd) begin
        if (wr_en === 1'b1) wr_pulses++;
        if (cmd_err === 1'b1) err_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_16bd);
        frame       = {1'b1, b};
        frame_valid = 1'b1;
        repeat (2) @(negedge clk_16bd);
        frame_valid = 1'b0;
        @(negedge clk_16bd);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        repeat (2) @(negedge clk_16bd);
    endtask

    initial begin
        int         wr0, er0;
        int         exp_errcnt;
        logic [3:0] hold_addr;
        logic [7:0] hold_data;

        vecs[0] = '{8'hA5, 8'h13, 8'h7E, 8'h37, 1'b1, 4'h3, 8'h7E, 1'b0};
        vecs[1] = '{8'hA5, 8'h13, 8'h7E, 8'h38, 1'b0, 4'h0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h13, 8'h7E, 8'h37, 1'b1, 4'h3, 8'h7E, 1'b0};
        vecs[3] = '{8'hA5, 8'h25, 8'h00, 8'h7F, 1'b0, 4'h0, 8'h00, 1'b1};
        vecs[4] = '{8'hA5, 8'h1F, 8'hC3, 8'h86, 1'b1, 4'hF, 8'hC3, 1'b0};
        vecs[5] = '{8'hA5, 8'h10, 8'hA5, 8'hEF, 1'b1, 4'h0, 8'hA5, 1'b0};
        vecs[6] = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 1'b0, 4'h0, 8'h00, 1'b1};

        // Reset with a sync byte already presented as a held level.
        rst         = 1'b1;
        frame       = {1'b0, 8'hA5};
        frame_valid = 1'b1;
        repeat (3) @(negedge clk_16bd);
        check("rst wr_en", wr_en, 0);
        check("rst cmd_err", cmd_err, 0);
        check("rst busy", busy, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst err_count", err_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk_16bd);
        check("held fv at reset release busy", busy, 0);
        frame_valid = 1'b0;
        repeat (2) @(negedge clk_16bd);

        exp_errcnt = 0;
        hold_addr  = 4'h0;
        hold_data  = 8'h00;
        for (int i = 0; i < 7; i++) begin
            wr0 = wr_pulses;
            er0 = err_pulses;
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            if (vecs[i].exp_wr) begin
                hold_addr = vecs[i].exp_addr;
                hold_data = vecs[i].exp_data;
            end
            if (vecs[i].exp_err) exp_errcnt++;
            check($sformatf("vec%0d wr pulses", i), wr_pulses - wr0, {31'b0, vecs[i].exp_wr});
            check($sformatf("vec%0d err pulses", i), err_pulses - er0, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d err_count", i), err_count, exp_errcnt);
            check($sformatf("vec%0d wr_addr", i), wr_addr, hold_addr);
            check($sformatf("vec%0d wr_data", i), wr_data, hold_data);
            check($sformatf("vec%0d busy", i), busy, 0);
        end

        // Junk ahead of a sync byte is dropped silently.
        wr0 = wr_pulses;
        er0 = err_pulses;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h11);
        check("junk busy", busy, 0);
        send_pkt(8'hA5, 8'h12, 8'h34, 8'h7C);
        check("junk wr pulses", wr_pulses - wr0, 1);
        check("junk err pulses", err_pulses - er0, 0);
        check("junk wr_addr", wr_addr, 4'h2);
        check("junk wr_data", wr_data, 8'h34);

        // Write strobe appears right after the edge that first samples the checksum byte.
        send_byte(8'hA5);
        send_byte(8'h13);
        send_byte(8'h7E);
        @(negedge clk_16bd);
        frame       = {1'b0, 8'h37};
        frame_valid = 1'b1;
        check("latency wr_en before edge", wr_en, 0);
        @(posedge clk_16bd); #1;
        check("latency wr_en pulse", wr_en, 1);
        check("latency wr_addr", wr_addr, 4'h3);
        check("latency busy drop", busy, 0);
        @(posedge clk_16bd); #1;
        check("latency wr_en width", wr_en, 0);
        frame_valid = 1'b0;
        repeat (2) @(negedge clk_16bd);

        // Timeout after the command byte.
        er0 = err_pulses;
        send_byte(8'hA5);
        @(negedge clk_16bd);
        frame       = {1'b0, 8'h13};
        frame_valid = 1'b1;
        @(posedge clk_16bd);
        for (int i = 1; i <= TO + 1; i++) begin
            @(posedge clk_16bd); #1;
            if (i == 2) frame_valid = 1'b0;
            if (i == TO - 1) begin
                check("timeout early cmd_err", cmd_err, 0);
                check("timeout early busy", busy, 1);
            end
            if (i == TO) begin
                check("timeout cmd_err", cmd_err, 1);
                check("timeout busy", busy, 0);
            end
            if (i == TO + 1) check("timeout cmd_err width", cmd_err, 0);
        end
        exp_errcnt++;
        check("timeout err_count", err_count, exp_errcnt);
        check("timeout err pulses", err_pulses - er0, 1);

        // Byte landing on the timeout cycle wins.
        wr0 = wr_pulses;
        er0 = err_pulses;
        send_byte(8'hA5);
        @(negedge clk_16bd);
        frame       = {1'b0, 8'h13};
        frame_valid = 1'b1;
        @(posedge clk_16bd);
        for (int i = 1; i <= TO - 1; i++) begin
            @(posedge clk_16bd); #1;
            if (i == 2) frame_valid = 1'b0;
        end
        @(negedge clk_16bd);
        frame       = {1'b0, 8'h7E};
        frame_valid = 1'b1;
        @(posedge clk_16bd); #1;
        check("edge byte cmd_err", cmd_err, 0);
        check("edge byte busy", busy, 1);
        repeat (2) @(negedge clk_16bd);
        frame_valid = 1'b0;
        send_byte(8'h37);
        repeat (2) @(negedge clk_16bd);
        check("edge byte wr pulses", wr_pulses - wr0, 1);
        check("edge byte err pulses", err_pulses - er0, 0);
        check("edge byte wr_data", wr_data, 8'h7E);
        check("edge byte err_count", err_count, exp_errcnt);

        // A held level counts as one byte only.
        wr0 = wr_pulses;
        er0 = err_pulses;
        @(negedge clk_16bd);
        frame       = {1'b0, 8'hA5};
        frame_valid = 1'b1;
        repeat (500) @(negedge clk_16bd);
        check("hold busy", busy, 1);
        frame_valid = 1'b0;
        @(negedge clk_16bd);
        send_byte(8'h13);
        send_byte(8'h7E);
        send_byte(8'h37);
        repeat (2) @(negedge clk_16bd);
        check("hold wr pulses", wr_pulses - wr0, 1);
        check("hold err pulses", err_pulses - er0, 0);

        // Saturation of the error counter.
        er0 = err_pulses;
        for (int i = 0; i < 260; i++) send_pkt(8'hA5, 8'h13, 8'h7E, 8'h38);
        check("sat err_count", err_count, 8'hFF);
        check("sat err pulses", err_pulses - er0, 260);

        // Reset mid-packet.
        send_byte(8'hA5);
        send_byte(8'h13);
        check("pre-reset busy", busy, 1);
        er0 = err_pulses;
        @(negedge clk_16bd);
        rst = 1'b1;
        @(negedge clk_16bd);
        rst = 1'b0;
        check("midrst wr_en", wr_en, 0);
        check("midrst cmd_err", cmd_err, 0);
        check("midrst busy", busy, 0);
        check("midrst wr_addr", wr_addr, 0);
        check("midrst wr_data", wr_data, 0);
        check("midrst err_count", err_count, 0);
        repeat (TO + 50) @(negedge clk_16bd);
        check("midrst err pulses", err_pulses - er0, 0);
        check("midrst busy later", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
